// File: rtl/camera_pkg.sv
// camera_pkg: shared types and constants for the MT9V034 parallel-output emulator.
// Holds the timing FSM state encoding, the test-pattern select codes and the
// LFSR seed/taps used when CAMERA_EMU_LFSR_EN is defined.
package camera_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEAD   = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_HBLANK = 3'd3,
    ST_VBLANK = 3'd4
  } state_e;

  localparam logic [1:0] PAT_HRAMP   = 2'd0;  // pixel = column
  localparam logic [1:0] PAT_VRAMP   = 2'd1;  // pixel = line
  localparam logic [1:0] PAT_CHECKER = 2'd2;  // 8x8 checkerboard
  localparam logic [1:0] PAT_ALT     = 2'd3;  // column + frame, or LFSR

  // x^10 + x^7 + 1, Fibonacci form: feedback from bits 9 and 6.
  localparam logic [9:0] LFSR_SEED = 10'h001;
  localparam logic [9:0] LFSR_TAPS = 10'h240;

  function automatic logic [9:0] lfsr_next(input logic [9:0] s);
    return {s[8:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/camera_pattern_gen.sv
// camera_pattern_gen: maps (column, line, frame, pattern) to a 10-bit pixel.
// Latency: combinational pixel; the LFSR state (CAMERA_EMU_LFSR_EN only) is a flop.
// Backpressure: none; the caller decides when a pixel is consumed (adv).
// Ports: c/l/f = column/line/frame count, pattern = latched select, pix = pixel.
//        clk/rst/seed/adv exist only when CAMERA_EMU_LFSR_EN is defined.
module camera_pattern_gen
  import camera_pkg::*;
#(
  parameter int CW = 10,
  parameter int LW = 9
) (
`ifdef CAMERA_EMU_LFSR_EN
  input  logic          clk,
  input  logic          rst,
  input  logic          seed,
  input  logic          adv,
`endif
  input  logic [CW-1:0] c,
  input  logic [LW-1:0] l,
  input  logic [7:0]    f,
  input  logic [1:0]    pattern,
  output logic [9:0]    pix
);

  logic [9:0] c10;
  logic [9:0] l10;
  logic [9:0] alt;

`ifdef CAMERA_EMU_LFSR_EN
  logic [9:0] lfsr_q;
  logic [9:0] lfsr_d;

  // Reseeded at every frame start so each frame carries the same sequence.
  always_comb begin
    lfsr_d = lfsr_q;
    if (seed) begin
      lfsr_d = LFSR_SEED;
    end else if (adv) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign alt = lfsr_q;
`else
  assign alt = c10 + 10'(f);
`endif

  always_comb begin
    c10 = 10'(c);
    l10 = 10'(l);
    case (pattern)
      PAT_HRAMP:   pix = c10;
      PAT_VRAMP:   pix = l10;
      PAT_CHECKER: pix = (c10[3] ^ l10[3]) ? 10'h3FF : 10'h000;
      default:     pix = alt;
    endcase
  end

endmodule

// File: rtl/camera_sensor_emu.sv
// camera_sensor_emu: MT9V034-style parallel output generator (FRAME_VALID, LINE_VALID, 10-bit DATA_OUT).
// Latency: all outputs registered; EN in IDLE gives FRAME_VALID on the next cycle.
// Backpressure: none; free-running once started, a frame always completes with its VBLANK.
// Ports: CLK/RST (sync, active high), EN run request, PATTERN select (latched at LEAD),
//        FRAME_VALID, LINE_VALID, DATA_OUT, FRAME_DONE pulse, FRAME_COUNT (wraps).
// Build option: CAMERA_EMU_LFSR_EN turns pattern 3 into a per-frame-reseeded LFSR.
module camera_sensor_emu
  import camera_pkg::*;
#(
  parameter int H       = 752,
  parameter int V       = 480,
  parameter int H_BLANK = 94,
  parameter int V_BLANK = 45
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic [1:0] PATTERN,
  output logic       FRAME_VALID,
  output logic       LINE_VALID,
  output logic [9:0] DATA_OUT,
  output logic       FRAME_DONE,
  output logic [7:0] FRAME_COUNT
);

  localparam int CW     = (H > 1) ? $clog2(H) : 1;
  localparam int LW     = (V > 1) ? $clog2(V) : 1;
  localparam int VB_CYC = V_BLANK * (H + H_BLANK);
  localparam int BW     = $clog2(VB_CYC);

  localparam logic [CW-1:0] COL_LAST  = CW'(H - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(V - 1);
  localparam logic [BW-1:0] HB_LAST   = BW'(H_BLANK - 1);
  localparam logic [BW-1:0] VB_LAST   = BW'(VB_CYC - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] col_q,   col_d;
  logic [LW-1:0] line_q,  line_d;
  logic [BW-1:0] bcnt_q,  bcnt_d;   // shared by HBLANK and VBLANK
  logic [7:0]    count_q, count_d;
  logic [1:0]    pat_q,   pat_d;
  logic          fv_q,    fv_d;
  logic          lv_q,    lv_d;
  logic [9:0]    data_q,  data_d;
  logic          done_q,  done_d;
  logic [9:0]    pix;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    line_d  = line_q;
    bcnt_d  = bcnt_q;
    count_d = count_q;
    pat_d   = pat_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (EN) state_d = ST_LEAD;
      end
      ST_LEAD: begin
        state_d = ST_ACTIVE;
        col_d   = '0;
        line_d  = '0;
      end
      ST_ACTIVE: begin
        if (col_q == COL_LAST) begin
          col_d  = '0;
          bcnt_d = '0;
          if (line_q == LINE_LAST) begin
            // Last line skips HBLANK; FV/LV drop together with the done pulse.
            state_d = ST_VBLANK;
            done_d  = 1'b1;
            count_d = count_q + 8'd1;
          end else begin
            state_d = ST_HBLANK;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      ST_HBLANK: begin
        if (bcnt_q == HB_LAST) begin
          state_d = ST_ACTIVE;
          bcnt_d  = '0;
          line_d  = line_q + 1'b1;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      ST_VBLANK: begin
        if (bcnt_q == VB_LAST) begin
          bcnt_d  = '0;
          line_d  = '0;
          state_d = EN ? ST_LEAD : ST_IDLE;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // LEAD lasts one cycle, so entering it is simply state_d == LEAD.
    if (state_d == ST_LEAD) pat_d = PATTERN;

    // Outputs are registered from the next state so they line up with it.
    fv_d   = (state_d == ST_LEAD) || (state_d == ST_ACTIVE) || (state_d == ST_HBLANK);
    lv_d   = (state_d == ST_ACTIVE);
    data_d = lv_d ? pix : 10'd0;
  end

  // pat_q is already loaded when the first pixel is computed (LEAD precedes ACTIVE).
  camera_pattern_gen #(
    .CW(CW),
    .LW(LW)
  ) u_pattern_gen (
`ifdef CAMERA_EMU_LFSR_EN
    .clk     (CLK),
    .rst     (RST),
    .seed    (state_d == ST_LEAD),
    .adv     (state_d == ST_ACTIVE),
`endif
    .c       (col_d),
    .l       (line_d),
    .f       (count_q),
    .pattern (pat_q),
    .pix     (pix)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      line_q  <= '0;
      bcnt_q  <= '0;
      count_q <= '0;
      pat_q   <= '0;
      fv_q    <= 1'b0;
      lv_q    <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      line_q  <= line_d;
      bcnt_q  <= bcnt_d;
      count_q <= count_d;
      pat_q   <= pat_d;
      fv_q    <= fv_d;
      lv_q    <= lv_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign FRAME_VALID = fv_q;
  assign LINE_VALID  = lv_q;
  assign DATA_OUT    = data_q;
  assign FRAME_DONE  = done_q;
  assign FRAME_COUNT = count_q;

endmodule

// File: tb/tb_camera_sensor_emu.sv
// Testbench for camera_sensor_emu with H=4, V=3, H_BLANK=2, V_BLANK=1.
// Expected frame events are queued up front; a negedge monitor pops and compares them.
module tb_camera_sensor_emu;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int HB = 2;
  localparam int VB = 1;

  // Offsets are counted from the cycle FRAME_VALID rises (offset 0).
  localparam int DONE_OFS = 17;  // LV high at 1-4, 7-10, 13-16; falls at 17
  localparam int PERIOD   = 23;

  localparam int K_FVR  = 0;
  localparam int K_PIX  = 1;
  localparam int K_DONE = 2;

  typedef struct {
    int kind;
    int ofs;   // -1: not checked
    int val;
  } ev_t;

  ev_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [1:0] pat = 2'd0;
  logic       fv, lv, done;
  logic [9:0] dat;
  logic [7:0] cnt;

  always #5 clk = ~clk;

  camera_sensor_emu #(
    .H(H), .V(V), .H_BLANK(HB), .V_BLANK(VB)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .EN          (en),
    .PATTERN     (pat),
    .FRAME_VALID (fv),
    .LINE_VALID  (lv),
    .DATA_OUT    (dat),
    .FRAME_DONE  (done),
    .FRAME_COUNT (cnt)
  );

  function automatic int exp_pix(input int p, input int c, input int l, input int f, input int k);
    logic [9:0] s;
    case (p)
      0: return c;
      1: return l;
      2: return ((((c >> 3) ^ (l >> 3)) & 1) != 0) ? 1023 : 0;
      default: begin
`ifdef CAMERA_EMU_LFSR_EN
        s = 10'h001;
        for (int i = 0; i < k; i++) s = {s[8:0], s[9] ^ s[6]};
`else
        s = 10'(c + f + (k * 0));
`endif
        return int'(s);
      end
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input int p, input int f, input int gap);
    int k;
    k = 0;
    sb.push_back(ev_t'{K_FVR, gap, 0});
    for (int l = 0; l < V; l++) begin
      for (int c = 0; c < H; c++) begin
        sb.push_back(ev_t'{K_PIX, 1 + l * (H + HB) + c, exp_pix(p, c, l, f, k)});
        k++;
      end
    end
    // DONE value packs {FV, LV, FRAME_COUNT}: both valids must be low.
    sb.push_back(ev_t'{K_DONE, DONE_OFS, (f + 1) % 256});
  endtask

  task automatic sb_check(input int kind, input int ofs, input int val);
    ev_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL sb_unexpected: got kind=%0d ofs=%0d val=%0d, expected no event", kind, ofs, val);
      return;
    end
    e = sb.pop_front();
    if (e.kind != kind || (e.ofs >= 0 && e.ofs != ofs) || e.val != val) begin
      n_bad++;
      $display("FAIL sb_event: got kind=%0d ofs=%0d val=%0d, expected kind=%0d ofs=%0d val=%0d (t=%0t)",
               kind, ofs, val, e.kind, e.ofs, e.val, $time);
    end
  endtask

  // Monitor
  initial begin
    int since;
    bit pfv;
    since = 0;
    pfv   = 1'b0;
    forever begin
      @(negedge clk);
      if (fv && !pfv) begin
        sb_check(K_FVR, since + 1, 0);
        since = 0;
      end else begin
        since++;
      end
      pfv = fv;
      if (lv)   sb_check(K_PIX, since, int'(dat));
      if (done) sb_check(K_DONE, since, int'({fv, lv, cnt}));
      if (!lv)  chk("data_zero_when_lv_low", int'(dat), 0);
    end
  end

  // Stimulus
  initial begin
    rst = 1'b1; en = 1'b0; pat = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fv", int'(fv), 0);
    chk("rst_lv", int'(lv), 0);
    chk("rst_data", int'(dat), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_count", int'(cnt), 0);

    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_fv", int'(fv), 0);

    // Three back-to-back frames: pattern 0, 1, 3; EN drops inside the third.
    push_frame(0, 0, -1);
    push_frame(1, 1, PERIOD);
    push_frame(3, 2, PERIOD);
    en = 1'b1; pat = 2'd0;
    @(posedge clk); #1;
    chk("fv_next_cycle", int'(fv), 1);
    chk("lv_in_lead", int'(lv), 0);
    pat = 2'd1;
    repeat (PERIOD) @(posedge clk); #1;
    pat = 2'd3;
    repeat (PERIOD) @(posedge clk); #1;
    repeat (5) @(posedge clk); #1;
    en = 1'b0;
    repeat (PERIOD + 10) @(posedge clk); #1;
    chk("stop_fv", int'(fv), 0);
    chk("stop_lv", int'(lv), 0);
    chk("stop_data", int'(dat), 0);
    chk("stop_count", int'(cnt), 3);

    // Reset during line 1: expect line 0 plus first pixel of line 1 only.
    sb.push_back(ev_t'{K_FVR, -1, 0});
    for (int c = 0; c < H; c++) sb.push_back(ev_t'{K_PIX, 1 + c, 0});
    sb.push_back(ev_t'{K_PIX, 1 + H + HB, 1});
    en = 1'b1; pat = 2'd1;
    @(posedge clk); #1;
    repeat (7) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_fv", int'(fv), 0);
    chk("midrst_lv", int'(lv), 0);
    chk("midrst_data", int'(dat), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_count", int'(cnt), 0);
    chk("midrst_sb_drained", sb.size(), 0);

    // Restart: first frame pattern 1 (starts at line 0), then 255 frames of pattern 3.
    push_frame(1, 0, -1);
    for (int f = 1; f < 256; f++) push_frame(3, f, PERIOD);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("fv_after_rst", int'(fv), 1);
    pat = 2'd3;
    repeat (255 * PERIOD + 3) @(posedge clk); #1;
    en = 1'b0;
    repeat (PERIOD + 15) @(posedge clk); #1;
    chk("wrap_fv", int'(fv), 0);
    chk("wrap_count", int'(cnt), 0);
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
